// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: 7-bit addressing, pointer byte,
// auto-increment reads/writes and repeated START, plus a local host port.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 4,
  localparam int        AW         = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  input  logic          host_we,
  output logic [7:0]    host_rdata,
  output logic          wr_strobe,
  output logic [AW-1:0] wr_addr,
  output logic          busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WDATA, DATA_ACK, RDATA, RACK, WAIT
  } state_t;

  logic [1:0] rst_pipe;
  logic       rst_n;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  // Bit 0 is SCL, bit 1 is SDA throughout the conditioning path.
  logic [1:0]    sync1, sync2, filt, filt_q;
  logic [CW-1:0] flt_cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1  <= {sda_in, scl_in};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;

  assign scl_f     = filt[0];
  assign sda_f     = filt[1];
  assign scl_rise  = scl_f & ~filt_q[0];
  assign scl_fall  = ~scl_f & filt_q[0];
  assign start_det = scl_f & filt_q[0] & filt_q[1] & ~sda_f;
  assign stop_det  = scl_f & filt_q[0] & ~filt_q[1] & sda_f;

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [6:0]    shreg, shreg_n;
  logic [AW-1:0] ptr, ptr_n, wr_addr_n;
  logic          rw, rw_n, ack_ok, ack_ok_n;
  logic          sda_oe_n, busy_n, wr_strobe_n, i2c_we;
  logic [7:0]    byte_in, rd_byte;
  logic [7:0]    regs [NUM_REGS];

  assign byte_in = {shreg, sda_f};
  assign rd_byte = regs[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_ok    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      ack_ok    <= ack_ok_n;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      wr_strobe <= wr_strobe_n;
      wr_addr   <= wr_addr_n;
    end
  end

  // START/STOP override every state; otherwise SDA only moves on SCL fall.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    ptr_n       = ptr;
    rw_n        = rw;
    ack_ok_n    = ack_ok;
    sda_oe_n    = sda_oe;
    busy_n      = busy;
    wr_strobe_n = 1'b0;
    wr_addr_n   = wr_addr;
    i2c_we      = 1'b0;

    if (start_det || stop_det) begin
      state_n   = start_det ? ADDR : IDLE;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      ack_ok_n  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n   = byte_in[6:0];
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
                rw_n    = byte_in[0];
              end else begin
                state_n = IDLE;
              end
            end
          end
        end
        PTR, WDATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in[6:0];
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_n = DATA_ACK;
              if (state == PTR) begin
                ptr_n = byte_in[AW-1:0];
              end else begin
                i2c_we      = 1'b1;
                wr_strobe_n = 1'b1;
                wr_addr_n   = ptr;
                ptr_n       = ptr + AW'(1);
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (rw) begin
              shreg_n   = rd_byte[6:0];
              sda_oe_n  = ~rd_byte[7];
              bit_cnt_n = '0;
              state_n   = RDATA;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = PTR;
            end
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              ack_ok_n  = 1'b0;
              state_n   = RACK;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shreg_n   = {shreg[5:0], 1'b0};
              sda_oe_n  = ~shreg[6];
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ack_ok_n = 1'b1;
              ptr_n    = ptr + AW'(1);
            end else begin
              state_n = WAIT;
            end
          end else if (scl_fall && ack_ok) begin
            ack_ok_n = 1'b0;
            shreg_n  = rd_byte[6:0];
            sda_oe_n = ~rd_byte[7];
            state_n  = RDATA;
          end
        end
        IDLE, WAIT: begin
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A bus commit to the same index as a host write takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      host_rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i2c_we && ptr == AW'(i))               regs[i] <= byte_in;
        else if (host_we && host_addr == AW'(i))   regs[i] <= host_wdata;
      end
      host_rdata <= regs[host_addr];
    end
  end

endmodule
